// File: rtl/cpe_fetch_queue_pkg.sv
// ============================================================================
// cpe_fetch_queue_pkg : shared constants for the instruction fetch queue
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpe_fetch_queue_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;
  localparam int INSTR_INC    = 4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : cpe_fetch_queue_pkg

`default_nettype wire

// File: rtl/cpe_sync_fifo.sv
// ============================================================================
// cpe_sync_fifo : single-clock FIFO with synchronous clear and occupancy count
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpe_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = i_push && !o_full;
    do_pop   = i_pop && !o_empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two
      if (do_push) begin
        mem_d[wr_ptr_q] = i_push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : cpe_sync_fifo

`default_nettype wire

// File: rtl/cpe_fetch_queue.sv
// ============================================================================
// cpe_fetch_queue : credit-based instruction prefetch with redirect/discard
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpe_fetch_queue
  import cpe_fetch_queue_pkg::*;
#(
  parameter int             XLEN     = XLEN_DEFAULT,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_w_i,
  input  logic            res_w_i_h,
  output logic            imem_req_w_o_h,
  output logic [XLEN-1:0] imem_addr_w_o,
  input  logic            imem_gnt_w_i_h,
  input  logic            imem_rvalid_w_i_h,
  input  logic [ILEN-1:0] imem_rdata_w_i,
  input  logic            redirect_w_i_h,
  input  logic [XLEN-1:0] redirect_pc_w_i,
  output logic            instr_valid_w_o_h,
  output logic [ILEN-1:0] instr_w_o,
  output logic [XLEN-1:0] instr_pc_w_o,
  input  logic            instr_ready_w_i_h,
  output logic            err_w_o_h
);

  // Outstanding can exceed DEPTH by the number of stale responses still owed
  localparam int CW  = $clog2(2 * DEPTH + 1);
  localparam int FCW = $clog2(DEPTH + 1);
  localparam int FW  = ILEN + XLEN;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic            err_q, err_d;

  logic [FCW-1:0]  fifo_count;
  logic            fifo_full, fifo_empty;
  logic [FW-1:0]   fifo_head;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_aligned;
  logic            gnt_fire, rv_live, rv_orphan, rv_drop, push, pop;

  assign redirect_aligned = redirect_pc_w_i & ~XLEN'(3);
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(outst_q) - (CW+1)'(discard_q);

  // Credit is derived from registered state only, never from rvalid
  assign imem_req_w_o_h = !res_w_i_h && !redirect_w_i_h && !fifo_full &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_addr_w_o  = fetch_pc_q;

  assign gnt_fire  = imem_req_w_o_h && imem_gnt_w_i_h;
  assign rv_live   = imem_rvalid_w_i_h && !res_w_i_h && (outst_q != '0);
  assign rv_orphan = imem_rvalid_w_i_h && !res_w_i_h && (outst_q == '0);
  assign rv_drop   = rv_live && (discard_q != '0);
  assign push      = rv_live && (discard_q == '0) && !redirect_w_i_h;

  assign instr_valid_w_o_h = !res_w_i_h && !fifo_empty;
  assign pop               = instr_valid_w_o_h && instr_ready_w_i_h;
  assign instr_w_o         = instr_valid_w_o_h ? fifo_head[FW-1:XLEN] : NOP_INSTR;
  assign instr_pc_w_o      = fifo_head[XLEN-1:0];
  assign err_w_o_h         = err_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(gnt_fire) - CW'(rv_live);
    discard_d  = discard_q;
    err_d      = err_q || rv_orphan;

    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_INC);
    end
    if (push) begin
      resp_pc_d = resp_pc_q + XLEN'(INSTR_INC);
    end
    if (rv_drop) begin
      discard_d = discard_q - CW'(1);
    end
    if (redirect_w_i_h) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      discard_d  = outst_q - CW'(rv_live);
    end
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
    end
  end

  cpe_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk_w_i),
    .rst         (res_w_i_h),
    .i_push      (push),
    .i_push_data ({imem_rdata_w_i, resp_pc_q}),
    .i_pop       (pop),
    .i_clear     (redirect_w_i_h),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count),
    .o_head      (fifo_head)
  );

endmodule : cpe_fetch_queue

`default_nettype wire
